l1_dcache_dm: RTL and testbench

- Direct-mapped, write-back, write-allocate cache that sits directly downstream of the multicycle RV32I core.
- Consumes the core's word-wide memory interface: mem_read/mem_write/mem_byte_enable/mem_address/mem_wdata in, mem_resp/mem_rdata out.
- Fetches and evicts whole 256-bit lines over a single-beat physical-memory interface (pmem_*).
- Serves both instruction fetch and data accesses; the core issues one request at a time.

---
 rtl/l1_dcache_dm.sv | 162 ++++++++++++++++
 tb/tb_l1_dcache_dm.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/l1_dcache_dm.sv
// rtl/l1_dcache_dm.sv - direct-mapped write-back write-allocate L1 cache, 256-bit lines
// Optional hit/miss counters are built when L1_DCACHE_PERF_CNT_EN is defined.
module l1_dcache_dm #(
  parameter int S_INDEX  = 3,
  parameter int S_OFFSET = 5
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         mem_read,
  input  logic         mem_write,
  input  logic [3:0]   mem_byte_enable,
  input  logic [31:0]  mem_address,
  input  logic [31:0]  mem_wdata,
  output logic         mem_resp,
  output logic [31:0]  mem_rdata,
  output logic         pmem_read,
  output logic         pmem_write,
  output logic [31:0]  pmem_address,
  output logic [255:0] pmem_wdata,
  input  logic [255:0] pmem_rdata,
  input  logic         pmem_resp
`ifdef L1_DCACHE_PERF_CNT_EN
  ,
  output logic [31:0]  hit_count,
  output logic [31:0]  miss_count
`endif
);

  localparam int NSETS = 2 ** S_INDEX;
  localparam int TAGW  = 32 - S_OFFSET - S_INDEX;

  typedef enum logic [1:0] {IDLE, COMPARE, WRITEBACK, ALLOCATE} state_e;

  state_e            r_state, w_next;
  logic [255:0]      r_data [NSETS];
  logic [TAGW-1:0]   r_tag  [NSETS];
  logic [NSETS-1:0]  r_valid;
  logic [NSETS-1:0]  r_dirty;

  logic [TAGW-1:0]    w_tag;
  logic [S_INDEX-1:0] w_index;
  logic [2:0]         w_word;
  logic [255:0]       w_line;
  logic [255:0]       w_merged;
  logic               w_hit;
  logic               w_fill;
  logic               w_wr_hit;
  logic               w_wb_done;
  logic               w_unused;

  assign w_tag    = mem_address[31:S_OFFSET+S_INDEX];
  assign w_index  = mem_address[S_OFFSET+S_INDEX-1:S_OFFSET];
  assign w_word   = mem_address[4:2];
  assign w_line   = r_data[w_index];
  assign w_hit    = r_valid[w_index] && (r_tag[w_index] == w_tag);
  assign w_unused = ^mem_address[1:0];

  always_comb begin
    w_merged = w_line;
    for (int b = 0; b < 4; b++) begin
      if (mem_byte_enable[b]) begin
        w_merged[{w_word, 2'(b), 3'b000} +: 8] = mem_wdata[8*b +: 8];
      end
    end
  end

  // Outputs are decoded from state alone, so an async reset drops pmem requests at once.
  always_comb begin
    w_next       = r_state;
    mem_resp     = 1'b0;
    mem_rdata    = 32'd0;
    pmem_read    = 1'b0;
    pmem_write   = 1'b0;
    pmem_address = 32'd0;
    pmem_wdata   = 256'd0;
    w_fill       = 1'b0;
    w_wr_hit     = 1'b0;
    w_wb_done    = 1'b0;
    case (r_state)
      IDLE: begin
        if (mem_read || mem_write) w_next = COMPARE;
      end
      COMPARE: begin
        if (w_hit) begin
          mem_resp  = 1'b1;
          mem_rdata = w_line[{w_word, 5'b00000} +: 32];
          w_wr_hit  = mem_write;
          w_next    = IDLE;
        end else if (r_dirty[w_index]) begin
          w_next = WRITEBACK;
        end else begin
          w_next = ALLOCATE;
        end
      end
      WRITEBACK: begin
        pmem_write   = 1'b1;
        pmem_address = {r_tag[w_index], w_index, {S_OFFSET{1'b0}}};
        pmem_wdata   = w_line;
        if (pmem_resp) begin
          w_wb_done = 1'b1;
          w_next    = ALLOCATE;
        end
      end
      ALLOCATE: begin
        pmem_read    = 1'b1;
        pmem_address = {w_tag, w_index, {S_OFFSET{1'b0}}};
        if (pmem_resp) begin
          w_fill = 1'b1;
          w_next = COMPARE;
        end
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_valid <= '0;
      r_dirty <= '0;
    end else begin
      r_state <= w_next;
      if (w_fill) begin
        r_valid[w_index] <= 1'b1;
        r_dirty[w_index] <= 1'b0;
      end
      if (w_wb_done) r_dirty[w_index] <= 1'b0;
      // A zero byte mask completes like a write but must not mark the line modified.
      if (w_wr_hit && (mem_byte_enable != 4'b0000)) r_dirty[w_index] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_fill) begin
      r_data[w_index] <= pmem_rdata;
      r_tag[w_index]  <= w_tag;
    end else if (w_wr_hit) begin
      r_data[w_index] <= w_merged;
    end
  end

`ifdef L1_DCACHE_PERF_CNT_EN
  logic r_refill;

  // The COMPARE that follows a fill is the same request, so it is not a fresh hit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hit_count  <= 32'd0;
      miss_count <= 32'd0;
      r_refill   <= 1'b0;
    end else begin
      if (w_fill) r_refill <= 1'b1;
      else if (r_state == COMPARE) r_refill <= 1'b0;
      if (r_state == COMPARE) begin
        if (!w_hit) miss_count <= miss_count + 32'd1;
        else if (!r_refill) hit_count <= hit_count + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_l1_dcache_dm.sv
// tb/tb_l1_dcache_dm.sv - directed vector bench for l1_dcache_dm with a line-memory model
module tb_l1_dcache_dm;

  localparam int DLY = 3;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         mem_read = 1'b0;
  logic         mem_write = 1'b0;
  logic [3:0]   mem_byte_enable = 4'd0;
  logic [31:0]  mem_address = 32'd0;
  logic [31:0]  mem_wdata = 32'd0;
  logic         mem_resp;
  logic [31:0]  mem_rdata;
  logic         pmem_read;
  logic         pmem_write;
  logic [31:0]  pmem_address;
  logic [255:0] pmem_wdata;
  logic [255:0] pmem_rdata = 256'd0;
  logic         pmem_resp = 1'b0;

  l1_dcache_dm dut (
    .clk(clk), .rst(rst),
    .mem_read(mem_read), .mem_write(mem_write), .mem_byte_enable(mem_byte_enable),
    .mem_address(mem_address), .mem_wdata(mem_wdata),
    .mem_resp(mem_resp), .mem_rdata(mem_rdata),
    .pmem_read(pmem_read), .pmem_write(pmem_write), .pmem_address(pmem_address),
    .pmem_wdata(pmem_wdata), .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_fail = 0;
  int viol = 0;

  logic [255:0] mem [logic [31:0]];

  int           res_lat, res_nrd, res_nwr;
  logic [31:0]  res_rdata, res_rdaddr, res_wraddr;
  logic [255:0] res_wline;

  typedef struct {
    logic        rd;
    logic        wr;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        chk_rd;
    logic [31:0] exp_rdata;
    int          exp_lat;
    int          exp_nrd;
    int          exp_nwr;
    logic [31:0] exp_rdaddr;
    logic [31:0] exp_wraddr;
    logic [31:0] exp_wr_w1;
  } vec_t;

  vec_t vecs [17];

  function automatic logic [255:0] get_line(input logic [31:0] a);
    logic [255:0] l;
    if (mem.exists(a)) return mem[a];
    for (int w = 0; w < 8; w++) l[w*32 +: 32] = (a + 32'(w*4)) ^ 32'hC0DE_0000;
    return l;
  endfunction

  task automatic chk32(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  task automatic do_access(input logic rd, input logic wr, input logic [3:0] be,
                           input logic [31:0] addr, input logic [31:0] wdata);
    int  rcyc, wcyc;
    bit  done;
    res_lat = 1; res_nrd = 0; res_nwr = 0;
    res_rdata = 0; res_rdaddr = 0; res_wraddr = 0; res_wline = '0;
    rcyc = 0; wcyc = 0; done = 0;
    @(negedge clk);
    mem_read = rd; mem_write = wr; mem_byte_enable = be; mem_address = addr; mem_wdata = wdata;
    for (int c = 0; c < 100 && !done; c++) begin
      @(negedge clk);
      res_lat++;
      pmem_resp = 1'b0;
      if (pmem_read && pmem_write) viol++;
      if (mem_resp) begin
        res_rdata = mem_rdata;
        done = 1;
      end else if (pmem_write) begin
        wcyc++;
        if (wcyc == DLY) begin
          pmem_resp = 1'b1;
          mem[pmem_address] = pmem_wdata;
          res_nwr++; res_wraddr = pmem_address; res_wline = pmem_wdata; wcyc = 0;
        end
      end else if (pmem_read) begin
        rcyc++;
        if (rcyc == DLY) begin
          pmem_resp = 1'b1;
          pmem_rdata = get_line(pmem_address);
          res_nrd++; res_rdaddr = pmem_address; rcyc = 0;
        end
      end
    end
    if (!done) begin
      n_cmp++; n_fail++;
      $display("FAIL timeout: no mem_resp for address 0x%08h within 100 cycles", addr);
    end
    @(posedge clk); #1;
    mem_read = 1'b0; mem_write = 1'b0;
    chk32("resp_one_cycle", 32'(mem_resp), 32'd0);
  endtask

  initial begin
    logic [255:0] l40;
    bit got;
    l40 = get_line(32'h40);
    l40[31:0]  = 32'hDEADBEEF;
    l40[63:32] = 32'h11223344;
    mem[32'h40] = l40;

    //               rd  wr  be    addr        wdata        chk exp_rdata     lat nrd nwr rdaddr      wraddr      wr_w1
    vecs[0]  = '{1'b1,1'b0,4'h0,32'h040,32'h0,         1'b1,32'hDEADBEEF,6,1,0,32'h040,32'h0,  32'h0};
    vecs[1]  = '{1'b0,1'b1,4'h5,32'h044,32'hA5A5A5A5,  1'b0,32'h0,       2,0,0,32'h0,  32'h0,  32'h0};
    vecs[2]  = '{1'b1,1'b0,4'h0,32'h044,32'h0,         1'b1,32'h11A533A5,2,0,0,32'h0,  32'h0,  32'h0};
    vecs[3]  = '{1'b1,1'b0,4'h0,32'h140,32'h0,         1'b1,32'hC0DE0140,9,1,1,32'h140,32'h040,32'h11A533A5};
    vecs[4]  = '{1'b1,1'b0,4'h0,32'h044,32'h0,         1'b1,32'h11A533A5,6,1,0,32'h040,32'h0,  32'h0};
    vecs[5]  = '{1'b1,1'b0,4'h0,32'h140,32'h0,         1'b1,32'hC0DE0140,6,1,0,32'h140,32'h0,  32'h0};
    vecs[6]  = '{1'b0,1'b1,4'h0,32'h140,32'hFFFFFFFF,  1'b0,32'h0,       2,0,0,32'h0,  32'h0,  32'h0};
    vecs[7]  = '{1'b1,1'b0,4'h0,32'h140,32'h0,         1'b1,32'hC0DE0140,2,0,0,32'h0,  32'h0,  32'h0};
    vecs[8]  = '{1'b1,1'b0,4'h0,32'h040,32'h0,         1'b1,32'hDEADBEEF,6,1,0,32'h040,32'h0,  32'h0};
    vecs[9]  = '{1'b1,1'b0,4'h0,32'h064,32'h0,         1'b1,32'hC0DE0064,6,1,0,32'h060,32'h0,  32'h0};
    vecs[10] = '{1'b1,1'b1,4'hF,32'h064,32'h12345678,  1'b0,32'h0,       2,0,0,32'h0,  32'h0,  32'h0};
    vecs[11] = '{1'b1,1'b0,4'h0,32'h060,32'h0,         1'b1,32'hC0DE0060,2,0,0,32'h0,  32'h0,  32'h0};
    vecs[12] = '{1'b1,1'b0,4'h0,32'h064,32'h0,         1'b1,32'h12345678,2,0,0,32'h0,  32'h0,  32'h0};
    vecs[13] = '{1'b1,1'b0,4'h0,32'h164,32'h0,         1'b1,32'hC0DE0164,9,1,1,32'h160,32'h060,32'h12345678};
    vecs[14] = '{1'b0,1'b1,4'hF,32'h01C,32'hCAFEF00D,  1'b0,32'h0,       6,1,0,32'h000,32'h0,  32'h0};
    vecs[15] = '{1'b1,1'b0,4'h0,32'h01C,32'h0,         1'b1,32'hCAFEF00D,2,0,0,32'h0,  32'h0,  32'h0};
    vecs[16] = '{1'b1,1'b0,4'h0,32'h018,32'h0,         1'b1,32'hC0DE0018,2,0,0,32'h0,  32'h0,  32'h0};

    #12;
    chk32("rst_mem_resp", 32'(mem_resp), 32'd0);
    chk32("rst_pmem_read", 32'(pmem_read), 32'd0);
    chk32("rst_pmem_write", 32'(pmem_write), 32'd0);
    chk32("rst_xfree", 32'(^{mem_rdata, pmem_address, pmem_wdata} === 1'bx), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 17; i++) begin
      do_access(vecs[i].rd, vecs[i].wr, vecs[i].be, vecs[i].addr, vecs[i].wdata);
      chk32($sformatf("v%0d_latency", i), 32'(res_lat), 32'(vecs[i].exp_lat));
      chk32($sformatf("v%0d_n_pmem_read", i), 32'(res_nrd), 32'(vecs[i].exp_nrd));
      chk32($sformatf("v%0d_n_pmem_write", i), 32'(res_nwr), 32'(vecs[i].exp_nwr));
      if (vecs[i].chk_rd) chk32($sformatf("v%0d_rdata", i), res_rdata, vecs[i].exp_rdata);
      if (vecs[i].exp_nrd != 0) chk32($sformatf("v%0d_fetch_addr", i), res_rdaddr, vecs[i].exp_rdaddr);
      if (vecs[i].exp_nwr != 0) begin
        chk32($sformatf("v%0d_wb_addr", i), res_wraddr, vecs[i].exp_wraddr);
        chk32($sformatf("v%0d_wb_word1", i), res_wline[63:32], vecs[i].exp_wr_w1);
      end
    end

    // Reset while a fill is outstanding: request must drop at once and the line stay invalid.
    @(negedge clk);
    mem_read = 1'b1; mem_write = 1'b0; mem_address = 32'h240;
    got = 0;
    for (int c = 0; c < 10 && !got; c++) begin
      @(negedge clk);
      if (pmem_read) got = 1;
    end
    chk32("alloc_reached", 32'(got), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk32("midrst_pmem_read", 32'(pmem_read), 32'd0);
    chk32("midrst_pmem_write", 32'(pmem_write), 32'd0);
    mem_read = 1'b0;
    @(negedge clk);
    rst = 1'b0;

    do_access(1'b1, 1'b0, 4'h0, 32'h240, 32'h0);
    chk32("refetch_n_read", 32'(res_nrd), 32'd1);
    chk32("refetch_addr", res_rdaddr, 32'h240);
    chk32("refetch_n_write", 32'(res_nwr), 32'd0);
    chk32("refetch_rdata", res_rdata, 32'hC0DE0240);
    chk32("refetch_latency", 32'(res_lat), 32'd6);

    do_access(1'b1, 1'b0, 4'h0, 32'h040, 32'h0);
    chk32("post_rst_n_read", 32'(res_nrd), 32'd1);
    chk32("post_rst_rdata", res_rdata, 32'hDEADBEEF);

    chk32("pmem_exclusive", 32'(viol), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
